spwm_gate_driver: RTL and testbench

- Downstream stage of the three-phase sine modulating-wave generator. It takes the three 12-bit modulating references and compares each against an internal symmetric triangular carrier to produce sinusoidal PWM.
- It emits three complementary high/low gate pairs with dead-time insertion, suitable for driving a three-phase inverter bridge.
- Includes an enable and a latched fault shutdown path.

---
 rtl/spwm_gate_driver.sv | 151 +++++++++++++++
 tb/tb_spwm_gate_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spwm_gate_driver.sv
// Three-phase sinusoidal PWM gate driver: symmetric triangle carrier,
// valley-latched references, per-phase dead-time and latched fault shutdown.
module spwm_gate_driver #(
    parameter int DEADTIME    = 24,
    parameter int CARRIER_MAX = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        fault,
    input  logic        fault_clr,
    input  logic [11:0] ref_a,
    input  logic [11:0] ref_b,
    input  logic [11:0] ref_c,
    output logic        gate_ah,
    output logic        gate_al,
    output logic        gate_bh,
    output logic        gate_bl,
    output logic        gate_ch,
    output logic        gate_cl,
    output logic [11:0] carrier,
    output logic        sync_valley,
    output logic        fault_latched
);

    localparam logic [11:0] CMAX = 12'(CARRIER_MAX);
    localparam logic [7:0]  DT   = 8'(DEADTIME);

    typedef enum logic {
        UP,
        DOWN
    } dir_t;

    dir_t        dir;
    dir_t        dir_nxt;
    logic [11:0] carrier_nxt;
    logic        run;
    logic        go;
    logic        run_q;
    logic        valley;

    logic [11:0] u      [3];
    logic [11:0] shadow [3];
    logic [7:0]  dt     [3];
    logic [2:0]  cmp;
    logic [2:0]  raw;
    logic [2:0]  gh;
    logic [2:0]  gl;

    // A fault seen this cycle already stops the modulator on this edge.
    assign run         = en & ~fault_latched;
    assign go          = run & ~fault;
    assign valley      = (carrier == 12'd0);
    assign sync_valley = run & valley;

    assign u[0] = {~ref_a[11], ref_a[10:0]};
    assign u[1] = {~ref_b[11], ref_b[10:0]};
    assign u[2] = {~ref_c[11], ref_c[10:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carrier <= 12'd0;
            dir     <= UP;
        end else begin
            carrier <= carrier_nxt;
            dir     <= dir_nxt;
        end
    end

    always_comb begin
        carrier_nxt = 12'd0;
        dir_nxt     = UP;
        if (go) begin
            unique case (dir)
                UP: begin
                    carrier_nxt = carrier + 12'd1;
                    dir_nxt     = (carrier == CMAX - 12'd1) ? DOWN : UP;
                end
                DOWN: begin
                    carrier_nxt = carrier - 12'd1;
                    dir_nxt     = (carrier == 12'd1) ? UP : DOWN;
                end
                default: begin
                    carrier_nxt = 12'd0;
                    dir_nxt     = UP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_latched <= 1'b0;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end else if (fault_clr) begin
            fault_latched <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= go;
        end
    end

    always_comb begin
        cmp = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cmp[i] = go & (shadow[i] > carrier);
        end
    end

    // Dead-time reloads on the same edge the compare bit flips, so the
    // outgoing gate is released one cycle later and the incoming one waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw <= 3'b000;
            gh  <= 3'b000;
            gl  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                shadow[i] <= 12'd2048;
                dt[i]     <= DT;
            end
        end else begin
            raw <= cmp;
            for (int i = 0; i < 3; i++) begin
                if (run && valley) begin
                    shadow[i] <= u[i];
                end
                if (!go || !run_q || (cmp[i] != raw[i])) begin
                    dt[i] <= DT;
                end else if (dt[i] != 8'd0) begin
                    dt[i] <= dt[i] - 8'd1;
                end
                gh[i] <= go & raw[i] & (dt[i] == 8'd0);
                gl[i] <= go & ~raw[i] & (dt[i] == 8'd0);
            end
        end
    end

    assign gate_ah = gh[0];
    assign gate_al = gl[0];
    assign gate_bh = gh[1];
    assign gate_bl = gl[1];
    assign gate_ch = gh[2];
    assign gate_cl = gl[2];

endmodule

// File: tb/tb_spwm_gate_driver.sv
// Directed bench for spwm_gate_driver: duty counts over full carrier
// periods, valley-only reference updates, fault, enable and async reset.
module tb_spwm_gate_driver;

    localparam int D   = 24;
    localparam int PER = 8190;

    logic        clk;
    logic        rst;
    logic        en;
    logic        fault;
    logic        fault_clr;
    logic [11:0] ref_a;
    logic [11:0] ref_b;
    logic [11:0] ref_c;
    logic        gate_ah;
    logic        gate_al;
    logic        gate_bh;
    logic        gate_bl;
    logic        gate_ch;
    logic        gate_cl;
    logic [11:0] carrier;
    logic        sync_valley;
    logic        fault_latched;
    logic [5:0]  gates;

    int errors;
    int checks;
    int overlaps;

    int ah_n, al_n, a0_n, bh_n, bl_n, b0_n, ch_n, cl_n;
    int valley_n, car_pk, car_end, car_chg, any_n;

    spwm_gate_driver #(
        .DEADTIME   (D),
        .CARRIER_MAX(4095)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .ref_a        (ref_a),
        .ref_b        (ref_b),
        .ref_c        (ref_c),
        .gate_ah      (gate_ah),
        .gate_al      (gate_al),
        .gate_bh      (gate_bh),
        .gate_bl      (gate_bl),
        .gate_ch      (gate_ch),
        .gate_cl      (gate_cl),
        .carrier      (carrier),
        .sync_valley  (sync_valley),
        .fault_latched(fault_latched)
    );

    assign gates = {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(gate_ah or gate_al or gate_bh or gate_bl or gate_ch or gate_cl) begin
        if ((gate_ah && gate_al) || (gate_bh && gate_bl) || (gate_ch && gate_cl))
            overlaps++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valley();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sync_valley && n < 9000);
        check("valley_seen", int'(sync_valley), 1);
    endtask

    task automatic count_any(input int n);
        any_n = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (gates != 6'd0) any_n++;
        end
    endtask

    // Called at a valley cycle; samples one full period starting there.
    task automatic measure(input int chg_at, input logic [11:0] chg_val);
        ah_n = 0; al_n = 0; a0_n = 0;
        bh_n = 0; bl_n = 0; b0_n = 0;
        ch_n = 0; cl_n = 0;
        valley_n = 0; car_pk = -1; car_end = -1; car_chg = -1;
        for (int k = 0; k < PER; k++) begin
            if (k > 0) @(negedge clk);
            ah_n += int'(gate_ah);
            al_n += int'(gate_al);
            a0_n += int'(!gate_ah && !gate_al);
            bh_n += int'(gate_bh);
            bl_n += int'(gate_bl);
            b0_n += int'(!gate_bh && !gate_bl);
            ch_n += int'(gate_ch);
            cl_n += int'(gate_cl);
            valley_n += int'(sync_valley);
            if (k == 4095) car_pk = int'(carrier);
            if (k == PER - 1) car_end = int'(carrier);
            if (k == chg_at) begin
                car_chg = int'(carrier);
                ref_a   = chg_val;
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        overlaps = 0;
        rst = 1'b1;
        en = 1'b0;
        fault = 1'b0;
        fault_clr = 1'b0;
        ref_a = 12'd0;
        ref_b = 12'd0;
        ref_c = 12'd0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_gates", int'(gates), 0);
        check("rst_carrier", int'(carrier), 0);
        check("rst_valley", int'(sync_valley), 0);
        check("rst_fault", int'(fault_latched), 0);
        rst = 1'b0;
        @(negedge clk);

        // startup at 50% references
        en = 1'b1;
        #1;
        check("start_carrier", int'(carrier), 0);
        check("start_valley", int'(sync_valley), 1);
        count_any(D + 1);
        check("start_dead", any_n, 0);
        @(negedge clk);
        check("start_gates", int'(gates), 6'b101010);

        wait_valley();
        measure(-1, 12'd0);
        check("mid_ah", ah_n, 4095 - D);
        check("mid_al", al_n, 4095 - D);
        check("mid_a_off", a0_n, 2 * D);
        check("mid_bh", bh_n, 4095 - D);
        check("mid_cl", cl_n, 4095 - D);
        check("mid_valleys", valley_n, 1);
        check("mid_peak", car_pk, 4095);
        check("mid_end", car_end, 1);

        // full-scale references
        ref_a = 12'h800;
        ref_b = 12'h7FF;
        ref_c = 12'h000;
        wait_valley();
        wait_valley();
        measure(-1, 12'h800);
        check("min_al", al_n, PER);
        check("min_ah", ah_n, 0);
        check("max_bh", bh_n, PER - D - 1);
        check("max_b_off", b0_n, D + 1);
        check("max_bl", bl_n, 0);
        check("zero_ch", ch_n, 4095 - D);
        check("fs_peak", car_pk, 4095);
        check("fs_valleys", valley_n, 1);

        // reference change mid-period takes effect at the next valley only
        ref_a = 12'd0;
        wait_valley();
        wait_valley();
        measure(2000, 12'd1000);
        check("chg_at", car_chg, 2000);
        check("chg_hold_ah", ah_n, 4095 - D);
        check("chg_hold_al", al_n, 4095 - D);
        wait_valley();
        measure(-1, 12'd1000);
        check("chg_new_ah", ah_n, 6095 - D);
        check("chg_new_al", al_n, 2095 - D);

        // fault shutdown and clear
        repeat (100) @(negedge clk);
        check("pre_fault_ah", int'(gate_ah), 1);
        fault = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        check("fault_gates", int'(gates), 0);
        check("fault_latch", int'(fault_latched), 1);
        count_any(50);
        check("fault_hold", any_n, 0);
        check("fault_carrier", int'(carrier), 0);
        check("fault_valley", int'(sync_valley), 0);
        fault = 1'b1;
        fault_clr = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        fault_clr = 1'b0;
        check("fault_wins", int'(fault_latched), 1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("clr_latch", int'(fault_latched), 0);
        check("clr_carrier", int'(carrier), 0);
        check("clr_valley", int'(sync_valley), 1);
        count_any(D + 1);
        check("clr_dead", any_n, 0);
        @(negedge clk);
        check("clr_gates", int'(gates), 6'b101010);

        // enable dropout and asynchronous reset
        repeat (200) @(negedge clk);
        check("pre_en_gates", int'(gates), 6'b101010);
        en = 1'b0;
        @(negedge clk);
        check("en_off_gates", int'(gates), 0);
        check("en_off_carrier", int'(carrier), 0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        repeat (D + 2) @(negedge clk);
        check("en_on_gates", int'(gates), 6'b101010);
        #2;
        rst = 1'b1;
        #1;
        check("arst_gates", int'(gates), 0);
        check("arst_carrier", int'(carrier), 0);
        check("arst_fault", int'(fault_latched), 0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_carrier", int'(carrier), 1);
        check("post_rst_gates", int'(gates), 0);

        check("no_overlap", overlaps, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
